regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 3: number of write-back requesters (2..4).
REQ-002 The block SHALL have parameter AW, default 5: register address width.
REQ-003 The block SHALL have parameter DW, default 32: register data width.
REQ-004 Port clk  input  1: single clock; all state updates on posedge clk.
REQ-005 Port rst  input  1: reset, synchronous and active-low.
REQ-006 Port req_valid  input  NREQ: requester i holds a write request.
REQ-007 Port req_addr  input  NREQ*AW: destination register of requester i, slice i.
REQ-008 Port req_data  input  NREQ*DW: write data of requester i, slice i.
REQ-009 Port req_ready  output  NREQ: one-hot grant; the request is accepted when req_valid[i] && req_ready[i].
REQ-010 Port write  output  1: register-file write enable.
REQ-011 Port waddr  output  AW: register-file write address.
REQ-012 Port writeData  output  DW: register-file write data.
REQ-013 Port drop_cnt  output  8: count of accepted writes to register 0.

Function
REQ-014 req_ready SHALL be combinational from req_valid and the round-robin pointer, with at most one bit set per cycle.
REQ-015 Arbitration SHALL be round-robin: search starts at index ptr, then ptr+1 ... mod NREQ; the first valid index wins.
REQ-016 After an accepted grant to index g, ptr SHALL become (g+1) mod NREQ; with no grant, ptr SHALL hold.
REQ-017 req_ready SHALL be all zero when req_valid is all zero.
REQ-018 An accepted request SHALL appear on write/waddr/writeData exactly 1 cycle later (registered outputs).
REQ-019 write SHALL be 1 for exactly one cycle per accepted request with a non-zero address; otherwise write SHALL be 0.
REQ-020 An accepted request to address 0 SHALL be consumed with write=0 and drop_cnt incremented; drop_cnt SHALL saturate at 255.
REQ-021 When write=0, waddr and writeData SHALL hold their previous values.
REQ-022 A requester not granted SHALL hold valid, addr and data stable until granted; the block SHALL not latch unaccepted requests.
REQ-023 Throughput SHALL be one accepted request per cycle, with no bubble between back-to-back grants.
REQ-024 Pointer wrap SHALL be exact for non-power-of-two NREQ: ptr never holds a value >= NREQ.

Reset
REQ-025 While rst=0 at a posedge, the block SHALL set ptr=0, write=0, waddr=0, writeData=0 and drop_cnt=0.
REQ-026 During reset, req_ready SHALL be forced to all zero, so no request is accepted.
REQ-027 A request accepted in the cycle before reset asserts SHALL be discarded; write stays 0 through reset.
REQ-028 On the first cycle after reset release, arbitration SHALL start from index 0.

Structure
REQ-029 NREQ_MAX (4), the counter width (8) and the grant-index type SHALL live in the shared package regfile_pkg.
REQ-030 The round-robin priority selection SHALL be the sub-module rr_pick: inputs valid and ptr; outputs one-hot grant and gnt_idx; purely combinational.
REQ-031 The top level SHALL contain only ptr, the output registers, drop_cnt and the muxing of the winner's addr/data.

Verification
REQ-032 Reset: rst=0 for 2 cycles with all req_valid=1 -> req_ready=0, write=0 and drop_cnt=0 throughout; the first grant after release goes to index 0.
REQ-033 Contention: all 3 valid and held (addr 1/2/3, data A/B/C) -> grants 0,1,2,0,1,2; write pulses carry (1,A),(2,B),(3,C) on consecutive cycles, each 1 cycle after its grant.
REQ-034 Fairness: requester 0 always valid, requester 2 raises valid once -> requester 2 is granted within 2 cycles and 0 is never granted twice in a row while 2 waits.
REQ-035 r0 drop: requester 1 writes addr 0 data 0xDEADBEEF -> write=0, waddr/writeData unchanged, drop_cnt 0->1; after 300 such writes drop_cnt=255.
REQ-036 Idle and hold: all valid=0 for 5 cycles -> write=0 and ptr unchanged; then a single requester 1 (addr 31, data 0x1) -> granted the same cycle, write=1 with waddr=31 one cycle later.
REQ-037 Reset mid-stream: rst=0 in the cycle after a grant to addr 7 -> no write to 7 appears, and post-release ptr=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-back arbiter slice.
package regfile_pkg;

   localparam int unsigned NREQ_MAX = 4;
   localparam int unsigned CNT_W    = 8;
   localparam int unsigned GIDX_W   = $clog2(NREQ_MAX);

   typedef logic [GIDX_W-1:0] gidx_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority pick: first valid index at or after ptr, wrapping mod NREQ.
module rr_pick
   import regfile_pkg::*;
#(
   parameter int unsigned NREQ = 3
) (
   input  logic [NREQ-1:0] valid,
   input  gidx_t           ptr,
   output logic [NREQ-1:0] grant,
   output gidx_t           gnt_idx
);

   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   int unsigned   idx;
   logic [IW-1:0] sel;
   logic          found;

   // Walk the ring once starting at ptr; wrap by subtraction so non-power-of-two NREQ is exact.
   always_comb begin
      grant   = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = 0;
      sel     = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = 32'(ptr) + k;
         if (idx >= NREQ) begin
            idx = idx - NREQ;
         end
         sel = IW'(idx);
         if (!found && valid[sel]) begin
            found      = 1'b1;
            grant[sel] = 1'b1;
            gnt_idx    = gidx_t'(idx);
         end
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: round-robin grant among NREQ requesters,
// one registered write per cycle, writes to register 0 dropped and counted.
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int unsigned NREQ = 3,
   parameter int unsigned AW   = 5,
   parameter int unsigned DW   = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*AW-1:0]   req_addr,
   input  logic [NREQ*DW-1:0]   req_data,
   output logic [NREQ-1:0]      req_ready,
   output logic                 write,
   output logic [AW-1:0]        waddr,
   output logic [DW-1:0]        writeData,
   output logic [CNT_W-1:0]     drop_cnt
);

   logic [NREQ-1:0] grant;
   gidx_t           gnt_idx;
   gidx_t           ptr;
   gidx_t           ptr_nxt;
   logic            accept;
   logic            write_q;
   logic [AW-1:0]   sel_addr;
   logic [DW-1:0]   sel_data;

   rr_pick #(.NREQ(NREQ)) u_pick (
      .valid   (req_valid),
      .ptr     (ptr),
      .grant   (grant),
      .gnt_idx (gnt_idx)
   );

   // Grants are suppressed while reset is held so nothing is accepted.
   assign req_ready = rst ? grant : '0;
   assign accept    = |req_ready;
   assign sel_addr  = req_addr[32'(gnt_idx)*AW +: AW];
   assign sel_data  = req_data[32'(gnt_idx)*DW +: DW];
   assign ptr_nxt   = (32'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + gidx_t'(1);

   always_ff @(posedge clk) begin
      if (!rst) begin
         ptr       <= '0;
         write_q   <= 1'b0;
         waddr     <= '0;
         writeData <= '0;
         drop_cnt  <= '0;
      end else begin
         write_q <= accept && (sel_addr != '0);
         if (accept) begin
            ptr <= ptr_nxt;
            if (sel_addr != '0) begin
               waddr     <= sel_addr;
               writeData <= sel_data;
            end else if (drop_cnt != '1) begin
               drop_cnt <= drop_cnt + CNT_W'(1);
            end
         end
      end
   end

   // A write captured just before reset asserts must never reach the register file.
   assign write = write_q & rst;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed plus randomized bench for regfile_wb_arbiter against a behavioural model.
module tb_regfile_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  req_valid;
   logic [14:0] req_addr;
   logic [95:0] req_data;
   logic [2:0]  req_ready;
   logic        write;
   logic [4:0]  waddr;
   logic [31:0] writeData;
   logic [7:0]  drop_cnt;

   always #5 clk = ~clk;

   regfile_wb_arbiter #(.NREQ(3), .AW(5), .DW(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .req_ready (req_ready),
      .write     (write),
      .waddr     (waddr),
      .writeData (writeData),
      .drop_cnt  (drop_cnt)
   );

   int tests = 0;
   int fails = 0;

   // requester state held by the bench
   logic [2:0]  vbits;
   logic [4:0]  aa [3];
   logic [31:0] da [3];

   // reference model state
   int          mptr  = 0;
   logic        mw    = 1'b0;
   logic [4:0]  mwa   = '0;
   logic [31:0] mwd   = '0;
   int          mdrop = 0;
   int          last_g;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input logic [2:0] v, input int p);
      for (int k = 0; k < 3; k++) begin
         if (v[(p + k) % 3]) return (p + k) % 3;
      end
      return -1;
   endfunction

   // One clock cycle: drive at negedge, check everything, advance the model at posedge.
   task automatic step(input logic r);
      int          g;
      logic [2:0]  exp_rdy;
      rst       = r;
      req_valid = vbits;
      req_addr  = {aa[2], aa[1], aa[0]};
      req_data  = {da[2], da[1], da[0]};
      #1;
      g       = pick(vbits, mptr);
      exp_rdy = (r && g >= 0) ? 3'(1 << g) : 3'b000;
      chk("ready", 32'(req_ready), 32'(exp_rdy));
      chk("write", 32'(write), 32'(mw & r));
      chk("waddr", 32'(waddr), 32'(mwa));
      chk("wdata", writeData, mwd);
      chk("drop",  32'(drop_cnt), 32'(mdrop));
      chk("ptr",   32'(dut.ptr), 32'(mptr));
      last_g = (r && g >= 0) ? g : -1;
      @(posedge clk);
      if (!r) begin
         mptr = 0; mw = 1'b0; mwa = '0; mwd = '0; mdrop = 0;
      end else if (g >= 0) begin
         mptr = (g + 1) % 3;
         if (aa[g] != 5'd0) begin
            mw = 1'b1; mwa = aa[g]; mwd = da[g];
         end else begin
            mw = 1'b0;
            if (mdrop < 255) mdrop++;
         end
      end else begin
         mw = 1'b0;
      end
      @(negedge clk);
   endtask

   initial begin
      int          saved_ptr;
      logic [4:0]  saved_wa;
      logic [31:0] saved_wd;
      logic [31:0] cdat [3];
      int          got2;
      cdat[0] = 32'hAAAA_0001; cdat[1] = 32'hBBBB_0002; cdat[2] = 32'hCCCC_0003;

      rst = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
      @(negedge clk);

      // Reset with all requesters valid, then contention round-robin
      vbits = 3'b111;
      for (int i = 0; i < 3; i++) begin aa[i] = 5'(i + 1); da[i] = cdat[i]; end
      step(1'b0);
      step(1'b0);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_drop",  32'(drop_cnt), 32'd0);
      for (int i = 0; i < 6; i++) begin
         step(1'b1);
         chk("cont_gnt",   32'(last_g), 32'(i % 3));
         chk("cont_write", 32'(write), 32'd1);
         chk("cont_waddr", 32'(waddr), 32'((i % 3) + 1));
         chk("cont_wdata", writeData, cdat[i % 3]);
      end

      // Fairness: requester 0 always valid, requester 2 raises once
      vbits = 3'b001;
      step(1'b1);
      step(1'b1);
      vbits = 3'b101;
      got2 = 0;
      for (int k = 0; k < 2 && got2 == 0; k++) begin
         step(1'b1);
         if (last_g == 2) got2 = 1;
      end
      chk("fair_r2", 32'(got2), 32'd1);
      vbits = 3'b001;
      step(1'b1);

      // Register-0 drop and saturation
      saved_wa = waddr; saved_wd = writeData;
      vbits = 3'b010; aa[1] = 5'd0; da[1] = 32'hDEAD_BEEF;
      step(1'b1);
      chk("drop_write", 32'(write), 32'd0);
      chk("drop_one",   32'(drop_cnt), 32'd1);
      chk("drop_wa",    32'(waddr), 32'(saved_wa));
      chk("drop_wd",    writeData, saved_wd);
      for (int k = 0; k < 299; k++) step(1'b1);
      chk("drop_sat", 32'(drop_cnt), 32'd255);

      // Idle hold, then a single requester
      vbits = 3'b000;
      saved_ptr = mptr;
      for (int k = 0; k < 5; k++) step(1'b1);
      chk("idle_ptr", 32'(dut.ptr), 32'(saved_ptr));
      vbits = 3'b010; aa[1] = 5'd31; da[1] = 32'h1;
      step(1'b1);
      chk("single_gnt",   32'(last_g), 32'd1);
      chk("single_write", 32'(write), 32'd1);
      chk("single_waddr", 32'(waddr), 32'd31);
      chk("single_wdata", writeData, 32'h1);

      // Reset the cycle after a grant to address 7
      vbits = 3'b001; aa[0] = 5'd7; da[0] = 32'h77;
      step(1'b1);
      chk("mid_gnt", 32'(last_g), 32'd0);
      vbits = 3'b000;
      step(1'b0);
      chk("mid_nowrite", 32'(write), 32'd0);
      step(1'b0);
      vbits = 3'b111;
      for (int i = 0; i < 3; i++) begin aa[i] = 5'(i + 1); da[i] = cdat[i]; end
      step(1'b1);
      chk("mid_first_gnt", 32'(last_g), 32'd0);

      // Randomized traffic; granted requests retire, waiting ones hold their payload
      vbits = 3'b000;
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < 3; i++) begin
            if (!vbits[i] && $urandom_range(0, 1) == 1) begin
               vbits[i] = 1'b1;
               aa[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
               da[i] = $urandom;
            end
         end
         step($urandom_range(0, 49) != 0);
         if (last_g >= 0) vbits[last_g] = 1'b0;
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
